// File: rtl/dds_load_sched.sv
// AD9850 parallel-load scheduler: arbitrates a master-reset request and two tuning-word
// requesters, then bit-bangs the 5-byte load (W0..W4) followed by an FQ_UD strobe.
module dds_load_sched #(
  parameter int CLK_DIV    = 2,
  parameter int RST_CYCLES = 8
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        init_req,
  input  logic        a_req,
  input  logic [31:0] a_word,
  input  logic [4:0]  a_phase,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [31:0] b_word,
  input  logic [4:0]  b_phase,
  output logic        b_ack,
  output logic        init_ack,
  output logic        busy,
  output logic        last_src,
  output logic        dds_reset,
  output logic        w_clk,
  output logic        fq_ud,
  output logic [7:0]  data
);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_BYTE_LO, S_BYTE_HI, S_UPDATE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cnt;
  logic [2:0]  r_idx;
  logic [31:0] r_word;
  logic [7:0]  r_data;
  logic        r_a_ack;
  logic        r_b_ack;
  logic        r_init_ack;
  logic        r_last_src;

  logic        w_cnt_done;
  logic        w_grant_b;
  logic        w_load;
  logic [7:0]  w_byte_next;

  assign w_cnt_done = (r_cnt == ((r_state == S_RESET) ? RST_LAST : DIV_LAST));
  // On contention the requester that did not win last time gets the grant.
  assign w_grant_b  = b_req & (~a_req | ~r_last_src);
  assign w_load     = (r_state == S_IDLE) & ~init_req & (a_req | b_req);

  always_comb begin
    case (r_idx)
      3'd0:    w_byte_next = r_word[31:24];
      3'd1:    w_byte_next = r_word[23:16];
      3'd2:    w_byte_next = r_word[15:8];
      default: w_byte_next = r_word[7:0];
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (init_req)    w_state_next = S_RESET;
        else if (w_load) w_state_next = S_BYTE_LO;
      end
      S_RESET:   if (w_cnt_done) w_state_next = S_IDLE;
      S_BYTE_LO: if (w_cnt_done) w_state_next = S_BYTE_HI;
      S_BYTE_HI: if (w_cnt_done) w_state_next = (r_idx == 3'd4) ? S_UPDATE : S_BYTE_LO;
      S_UPDATE:  if (w_cnt_done) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_word     <= '0;
      r_data     <= '0;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_init_ack <= 1'b0;
      r_last_src <= 1'b1;
    end else begin
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_init_ack <= 1'b0;
      r_cnt      <= (r_state == S_IDLE || w_cnt_done) ? 8'd0 : r_cnt + 8'd1;
      if (r_state == S_IDLE) begin
        if (init_req) begin
          r_init_ack <= 1'b1;
        end else if (w_load) begin
          r_a_ack    <= ~w_grant_b;
          r_b_ack    <= w_grant_b;
          r_last_src <= w_grant_b;
          r_word     <= w_grant_b ? b_word : a_word;
          r_idx      <= '0;
          r_data     <= {(w_grant_b ? b_phase : a_phase), 3'b000};
        end
      end
      // Next byte is presented as BYTE_HI ends, so it is stable for the whole BYTE_LO.
      if (r_state == S_BYTE_HI && w_cnt_done && r_idx != 3'd4) begin
        r_idx  <= r_idx + 3'd1;
        r_data <= w_byte_next;
      end
    end
  end

  always_comb begin
    dds_reset = (r_state == S_RESET);
    w_clk     = (r_state == S_BYTE_HI);
    fq_ud     = (r_state == S_UPDATE);
    busy      = (r_state != S_IDLE);
    data      = r_data;
    a_ack     = r_a_ack;
    b_ack     = r_b_ack;
    init_ack  = r_init_ack;
    last_src  = r_last_src;
  end

endmodule

// File: tb/tb_dds_load_sched.sv
// Directed bench for dds_load_sched: default instance plus a CLK_DIV=1 instance.
module tb_dds_load_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_req = 1'b0, a_req = 1'b0, b_req = 1'b0;
  logic [31:0] a_word = '0, b_word = '0;
  logic [4:0]  a_phase = '0, b_phase = '0;
  logic        a_ack, b_ack, init_ack, busy, last_src, dds_reset, w_clk, fq_ud;
  logic [7:0]  data;

  logic        init_req1 = 1'b0, a_req1 = 1'b0, b_req1 = 1'b0;
  logic        a_ack1, b_ack1, init_ack1, busy1, last_src1, dds_reset1, w_clk1, fq_ud1;
  logic [7:0]  data1;

  int checks = 0;
  int failures = 0;

  int n_busy, n_fq, n_rst, n_conf, nb, nacks, idx_init;
  logic [7:0] bytes_seen [8];
  int         ack_idx [8];
  logic       ack_src [8];
  logic       ack_ls  [8];

  always #5 clk = ~clk;

  dds_load_sched u_dut (
    .clk_sys(clk), .rst(rst), .init_req(init_req),
    .a_req(a_req), .a_word(a_word), .a_phase(a_phase), .a_ack(a_ack),
    .b_req(b_req), .b_word(b_word), .b_phase(b_phase), .b_ack(b_ack),
    .init_ack(init_ack), .busy(busy), .last_src(last_src),
    .dds_reset(dds_reset), .w_clk(w_clk), .fq_ud(fq_ud), .data(data)
  );

  dds_load_sched #(.CLK_DIV(1)) u_dut1 (
    .clk_sys(clk), .rst(rst), .init_req(init_req1),
    .a_req(a_req1), .a_word(a_word), .a_phase(a_phase), .a_ack(a_ack1),
    .b_req(b_req1), .b_word(b_word), .b_phase(b_phase), .b_ack(b_ack1),
    .init_ack(init_ack1), .busy(busy1), .last_src(last_src1),
    .dds_reset(dds_reset1), .w_clk(w_clk1), .fq_ud(fq_ud1), .data(data1)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Samples the default instance for n cycles, recording acks, bytes and strobes.
  task automatic observe(input int n, input bit hold, input bit scramble);
    logic prev_w;
    prev_w = 1'b0;
    n_busy = 0; n_fq = 0; n_rst = 0; n_conf = 0; nb = 0; nacks = 0; idx_init = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (fq_ud) n_fq++;
      if (dds_reset) n_rst++;
      if ((w_clk && fq_ud) || (dds_reset && (w_clk || fq_ud)) || (a_ack && b_ack)) n_conf++;
      if (w_clk && !prev_w) begin
        if (nb < 8) bytes_seen[nb] = data;
        nb++;
      end
      if (init_ack) begin
        if (idx_init < 0) idx_init = i;
        if (!hold) init_req = 1'b0;
      end
      if (a_ack || b_ack) begin
        if (nacks < 8) begin
          ack_idx[nacks] = i;
          ack_src[nacks] = b_ack;
          ack_ls[nacks]  = last_src;
        end
        nacks++;
        if (!hold) begin
          if (a_ack) a_req = 1'b0;
          if (b_ack) b_req = 1'b0;
        end
        if (scramble) begin
          a_word  = 32'hFFFF_FFFF;
          a_phase = 5'h1F;
        end
      end
      prev_w = w_clk;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; init_req = 1'b1; a_req = 1'b1; b_req = 1'b1; a_req1 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({dds_reset, w_clk, fq_ud, busy, a_ack, b_ack, init_ack} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {dds_reset, w_clk, fq_ud, busy, a_ack, b_ack, init_ack});
    end
    checks++;
    if (data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", data); end
    checks++;
    if (last_src !== 1'b1) begin failures++; $display("FAIL reset_last_src: got %b expected 1", last_src); end
    checks++;
    if ({dds_reset1, w_clk1, fq_ud1, busy1, a_ack1, last_src1, data1} !== {6'b000001, 8'h00}) begin
      failures++;
      $display("FAIL reset_div1: got %b expected 00000100000000", {dds_reset1, w_clk1, fq_ud1, busy1, a_ack1, last_src1, data1});
    end
    init_req = 1'b0; a_req = 1'b0; b_req = 1'b0; a_req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_load();
    logic [7:0] exp_b [5];
    exp_b = '{8'h18, 8'h12, 8'h34, 8'h56, 8'h78};
    do_reset();
    a_word = 32'h1234_5678; a_phase = 5'h03; a_req = 1'b1;
    observe(30, 1'b0, 1'b0);
    checks++;
    if (nacks !== 1 || ack_idx[0] !== 0 || ack_src[0] !== 1'b0) begin
      failures++;
      $display("FAIL single_ack: got count=%0d idx=%0d src=%b expected 1/0/0", nacks, ack_idx[0], ack_src[0]);
    end
    checks++;
    if (n_busy !== 22) begin failures++; $display("FAIL single_busy: got %0d expected 22", n_busy); end
    checks++;
    if (n_fq !== 2) begin failures++; $display("FAIL single_fq_ud: got %0d expected 2", n_fq); end
    checks++;
    if (nb !== 5) begin failures++; $display("FAIL single_wclk_edges: got %0d expected 5", nb); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bytes_seen[k] !== exp_b[k]) begin
        failures++;
        $display("FAIL single_byte%0d: got %h expected %h", k, bytes_seen[k], exp_b[k]);
      end
    end
    checks++;
    if (n_conf !== 0 || n_rst !== 0) begin
      failures++;
      $display("FAIL single_overlap: got conflicts=%0d dds_reset=%0d expected 0/0", n_conf, n_rst);
    end
  endtask

  task automatic test_input_stability();
    logic [7:0] exp_b [5];
    exp_b = '{8'hF8, 8'hA5, 8'hC3, 8'h0F, 8'h96};
    do_reset();
    a_word = 32'hA5C3_0F96; a_phase = 5'h1F; a_req = 1'b1;
    observe(30, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bytes_seen[k] !== exp_b[k]) begin
        failures++;
        $display("FAIL stable_byte%0d: got %h expected %h", k, bytes_seen[k], exp_b[k]);
      end
    end
    checks++;
    if (n_fq !== 2 || n_busy !== 22) begin
      failures++;
      $display("FAIL stable_window: got fq=%0d busy=%0d expected 2/22", n_fq, n_busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    a_word = 32'h0000_0001; b_word = 32'h8000_0000; a_req = 1'b1; b_req = 1'b1;
    observe(100, 1'b1, 1'b0);
    checks++;
    if (nacks < 4) begin failures++; $display("FAIL contend_count: got %0d expected >=4", nacks); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ack_src[k] !== k[0] || ack_ls[k] !== k[0] || ack_idx[k] !== 23 * k) begin
        failures++;
        $display("FAIL contend_grant%0d: got src=%b last_src=%b idx=%0d expected %b/%b/%0d",
                 k, ack_src[k], ack_ls[k], ack_idx[k], k[0], k[0], 23 * k);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_init_priority();
    do_reset();
    init_req = 1'b1; a_req = 1'b1; b_req = 1'b1;
    observe(40, 1'b0, 1'b0);
    checks++;
    if (idx_init !== 0) begin failures++; $display("FAIL init_ack_idx: got %0d expected 0", idx_init); end
    checks++;
    if (n_rst !== 8) begin failures++; $display("FAIL init_reset_len: got %0d expected 8", n_rst); end
    checks++;
    if (nacks !== 2 || ack_idx[0] !== 9 || ack_src[0] !== 1'b0 || ack_idx[1] !== 32 || ack_src[1] !== 1'b1) begin
      failures++;
      $display("FAIL init_then_loads: got n=%0d A@%0d src=%b B@%0d src=%b expected 2 0@9 1@32",
               nacks, ack_idx[0], ack_src[0], ack_idx[1], ack_src[1]);
    end
    checks++;
    if (n_conf !== 0) begin failures++; $display("FAIL init_overlap: got %0d expected 0", n_conf); end
  endtask

  task automatic test_mid_reset();
    int   nrise, nfq;
    logic prev_w, got;
    do_reset();
    a_word = 32'h1234_5678; a_phase = 5'h03; a_req = 1'b1;
    nrise = 0; nfq = 0; prev_w = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (a_ack) a_req = 1'b0;
      if (fq_ud) nfq++;
      if (w_clk && !prev_w) nrise++;
      prev_w = w_clk;
    end
    checks++;
    if (nrise !== 3 || w_clk !== 1'b1 || data !== 8'h34 || nfq !== 0) begin
      failures++;
      $display("FAIL midrst_pre: got rises=%0d w_clk=%b data=%h fq=%0d expected 3/1/34/0", nrise, w_clk, data, nfq);
    end
    rst = 1'b1; b_req = 1'b1; b_word = 32'hCAFE_0001;
    @(negedge clk);
    checks++;
    if ({dds_reset, w_clk, fq_ud, busy, a_ack, b_ack, init_ack, data} !== 15'b0 || last_src !== 1'b1) begin
      failures++;
      $display("FAIL midrst_outputs: got %b last_src=%b expected all 0, last_src 1",
               {dds_reset, w_clk, fq_ud, busy, a_ack, b_ack, init_ack, data}, last_src);
    end
    rst = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      @(negedge clk);
      if (b_ack) got = 1'b1;
    end
    b_req = 1'b0;
    checks++;
    if (got !== 1'b1) begin failures++; $display("FAIL midrst_b_grant: got %b expected 1", got); end
    observe(30, 1'b0, 1'b0);
    checks++;
    if (nacks !== 0 || n_fq !== 2) begin
      failures++;
      $display("FAIL midrst_after: got acks=%0d fq=%0d expected 0/2", nacks, n_fq);
    end
  endtask

  task automatic test_clkdiv1();
    int   nbusy, nfq, nrise, ntog, nack, nbyte;
    logic prev_w, prev_busy;
    logic [7:0] got_b [5];
    logic [7:0] exp_b [5];
    exp_b = '{8'h18, 8'h12, 8'h34, 8'h56, 8'h78};
    got_b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    a_word = 32'h1234_5678; a_phase = 5'h03; a_req1 = 1'b1;
    nbusy = 0; nfq = 0; nrise = 0; ntog = 0; nack = 0; nbyte = 0;
    prev_w = 1'b0; prev_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_ack1) begin nack++; a_req1 = 1'b0; end
      if (busy1) nbusy++;
      if (fq_ud1) nfq++;
      if (w_clk1 && !prev_w) begin
        if (nbyte < 5) got_b[nbyte] = data1;
        nbyte++;
        nrise++;
      end
      if (busy1 && prev_busy && !fq_ud1 && (w_clk1 != prev_w)) ntog++;
      prev_w = w_clk1;
      prev_busy = busy1;
    end
    checks++;
    if (nbusy !== 11 || nfq !== 1 || nack !== 1) begin
      failures++;
      $display("FAIL div1_window: got busy=%0d fq=%0d acks=%0d expected 11/1/1", nbusy, nfq, nack);
    end
    checks++;
    if (nrise !== 5 || ntog !== 9) begin
      failures++;
      $display("FAIL div1_wclk: got rises=%0d toggles=%0d expected 5/9", nrise, ntog);
    end
    checks++;
    if (got_b !== exp_b) begin
      failures++;
      $display("FAIL div1_bytes: got %h %h %h %h %h expected 18 12 34 56 78",
               got_b[0], got_b[1], got_b[2], got_b[3], got_b[4]);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_input_stability();
    test_back_to_back();
    test_init_priority();
    test_mid_reset();
    test_clkdiv1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
